crc32_frame_checker: RTL

Receive-side counterpart of the byte-wise CRC-32 (IEEE 802.3, reflected poly 0xEDB88320, init 0xFFFFFFFF) generator used on the UART/SPI link. It accepts a byte stream in which every frame carries 4 trailing CRC bytes. It forwards the payload with the CRC bytes stripped, and reports one status pulse per frame: good, CRC error, or runt. It sits between the byte deframer and the command/packet parser.

---
 rtl/crc32_pkg.sv | 24 ++
 rtl/crc32_frame_checker.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/crc32_pkg.sv
// CRC-32 (IEEE 802.3, reflected) constants and byte-step function shared by
// the link CRC generator and the receive-side frame checker.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_STREAM = 1'b1
  } chk_state_t;

  // One byte of the reflected CRC, processed LSB first. No final inversion.
  function automatic logic [31:0] next_crc32(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC32_POLY) : (r >> 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: strips the 4 trailing CRC bytes, forwards
// the payload and emits one good / CRC-error / runt status pulse per frame.
module crc32_frame_checker
  import crc32_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             sts_valid,
  output logic             sts_ok,
  output logic             sts_crc_err,
  output logic             sts_runt,
  output logic [LEN_W-1:0] sts_len
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  chk_state_t       state_reg, state_next;
  logic [2:0]       fill_reg, fill_next;
  logic [31:0]      crc_reg;
  logic [31:0]      crc_step;
  logic [7:0]       dly_reg [0:3];
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] len_inc;
  logic             accept;
  logic             emit;
  logic             runt;

  logic             m_valid_reg;
  logic [7:0]       m_data_reg;
  logic             m_last_reg;
  logic             sts_valid_reg;
  logic             sts_ok_reg;
  logic             sts_crc_err_reg;
  logic             sts_runt_reg;
  logic [LEN_W-1:0] sts_len_reg;

  assign s_ready  = !m_valid_reg || m_ready;
  assign accept   = s_valid && s_ready;
  assign crc_step = next_crc32(crc_reg, s_data);
  assign len_inc  = (len_reg == LEN_MAX) ? len_reg : (len_reg + LEN_ONE);

  // FILL collects the first four bytes of a frame; STREAM emits the oldest
  // buffered byte on every accepted beat. Every s_last returns to FILL.
  always_comb begin
    state_next = state_reg;
    fill_next  = fill_reg;
    emit       = 1'b0;
    runt       = 1'b0;
    if (accept) begin
      case (state_reg)
        ST_FILL: begin
          if (s_last) begin
            runt      = 1'b1;
            fill_next = 3'd0;
          end else begin
            fill_next = fill_reg + 3'd1;
            if (fill_reg == 3'd3) begin
              state_next = ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          emit = 1'b1;
          if (s_last) begin
            state_next = ST_FILL;
            fill_next  = 3'd0;
          end
        end
        default: begin
          state_next = ST_FILL;
          fill_next  = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_FILL;
      fill_reg        <= 3'd0;
      crc_reg         <= CRC32_INIT;
      len_reg         <= '0;
      for (int i = 0; i < 4; i++) dly_reg[i] <= 8'd0;
      m_valid_reg     <= 1'b0;
      m_data_reg      <= 8'd0;
      m_last_reg      <= 1'b0;
      sts_valid_reg   <= 1'b0;
      sts_ok_reg      <= 1'b0;
      sts_crc_err_reg <= 1'b0;
      sts_runt_reg    <= 1'b0;
      sts_len_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      fill_reg      <= fill_next;
      sts_valid_reg <= accept && s_last;

      if (accept) begin
        crc_reg    <= s_last ? CRC32_INIT : crc_step;
        dly_reg[0] <= s_data;
        for (int i = 1; i < 4; i++) dly_reg[i] <= dly_reg[i-1];
      end

      // A load wins over a drain so back-to-back bytes keep m_valid high.
      if (emit) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= dly_reg[3];
        m_last_reg  <= s_last;
        len_reg     <= s_last ? '0 : len_inc;
      end else if (m_valid_reg && m_ready) begin
        m_valid_reg <= 1'b0;
      end

      if (accept && s_last) begin
        // The trailing CRC bytes drive a good frame's register to the residue.
        sts_ok_reg      <= emit && (crc_step == CRC32_RESIDUE);
        sts_crc_err_reg <= emit && (crc_step != CRC32_RESIDUE);
        sts_runt_reg    <= runt;
        sts_len_reg     <= emit ? len_inc : '0;
        len_reg         <= '0;
      end
    end
  end

  assign m_valid     = m_valid_reg;
  assign m_data      = m_data_reg;
  assign m_last      = m_last_reg;
  assign sts_valid   = sts_valid_reg;
  assign sts_ok      = sts_ok_reg;
  assign sts_crc_err = sts_crc_err_reg;
  assign sts_runt    = sts_runt_reg;
  assign sts_len     = sts_len_reg;

endmodule
